// File: rtl/qspi_flash_seq_if.sv
// Bus bundle between the flash command sequencer, its host and the QSPI register wrapper.
// Every *_vld/*_rdy pair: a transfer happens on a clock edge where both are high; the sender holds payload stable while vld is high and rdy is low.
interface qspi_flash_seq_if #(
  parameter int LEN_W = 8
);
  logic             cmd_vld;
  logic             cmd_rdy;
  logic [7:0]       cmd_opcode;
  logic [23:0]      cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_quad;

  logic             rd_vld;
  logic             rd_rdy;
  logic [7:0]       rd_dat;
  logic             done;
  logic             err;

  logic             q_req_vld;
  logic             q_req_rdy;
  logic [3:0]       q_req_addr;
  logic             q_req_read;
  logic [7:0]       q_req_dat;

  logic             q_rsp_vld;
  logic             q_rsp_rdy;
  logic [7:0]       q_rsp_dat;

  modport master (
    input  cmd_vld, cmd_opcode, cmd_addr, cmd_len, cmd_quad, rd_rdy,
           q_req_rdy, q_rsp_vld, q_rsp_dat,
    output cmd_rdy, rd_vld, rd_dat, done, err,
           q_req_vld, q_req_addr, q_req_read, q_req_dat, q_rsp_rdy
  );

  modport slave (
    output cmd_vld, cmd_opcode, cmd_addr, cmd_len, cmd_quad, rd_rdy,
           q_req_rdy, q_rsp_vld, q_rsp_dat,
    input  cmd_rdy, rd_vld, rd_dat, done, err,
           q_req_vld, q_req_addr, q_req_read, q_req_dat, q_rsp_rdy
  );
endinterface

// File: rtl/qspi_flash_seq.sv
// Turns one flash read command into the register-access sequence of the QSPI wrapper and streams the read bytes out.
// Optional macro QSPI_SEQ_TIMEOUT_EN adds a per-access response timeout with a sticky err flag.
module qspi_flash_seq #(
  parameter int         LEN_W       = 8,
  parameter logic [3:0] DIV         = 4'd1,
  parameter logic [1:0] MODE        = 2'd0,
  parameter int         DUMMY_BYTES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  qspi_flash_seq_if.master  bus,
  output logic [3:0]        dbg_state_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_CFG0, S_CS_LO, S_OPC, S_TYPE, S_ADDR, S_DUMMY, S_RD, S_CS_HI, S_DONE
  } state_t;

  localparam logic [1:0] DUMMY_LAST = 2'((DUMMY_BYTES > 0) ? DUMMY_BYTES - 1 : 0);

  state_t           state_q, state_d;
  logic             wait_q, wait_d;     // 0: ISSUE sub-phase, 1: WAIT sub-phase
  logic [1:0]       idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       opc_q, opc_d;
  logic [23:0]      addr_q, addr_d;
  logic             quad_q, quad_d;

  logic   cmd_fire, rsp_fire, tmo_hit, busy;
  logic   req_vld, req_read, rsp_rdy, rd_vld;
  logic [3:0] req_addr;
  logic [7:0] req_dat;
  state_t after_addr, after_dummy;

  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign cmd_fire = bus.cmd_vld && (state_q == S_IDLE);
  assign rsp_fire = bus.q_rsp_vld && rsp_rdy;

  assign after_dummy = (len_q != '0) ? S_RD : S_CS_HI;
  assign after_addr  = (quad_q && (DUMMY_BYTES > 0)) ? S_DUMMY : after_dummy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wait_q  <= 1'b0;
      idx_q   <= 2'd0;
      len_q   <= '0;
      opc_q   <= 8'h00;
      addr_q  <= 24'h0;
      quad_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      opc_q   <= opc_d;
      addr_q  <= addr_d;
      quad_q  <= quad_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    idx_d   = idx_q;
    len_d   = len_q;
    opc_d   = opc_q;
    addr_d  = addr_q;
    quad_d  = quad_q;
    if (cmd_fire) begin
      opc_d   = bus.cmd_opcode;
      addr_d  = bus.cmd_addr;
      len_d   = bus.cmd_len;
      quad_d  = bus.cmd_quad;
      idx_d   = 2'd0;
      wait_d  = 1'b0;
      state_d = S_CFG0;
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end else if (busy && !wait_q) begin
      if (bus.q_req_rdy) wait_d = 1'b1;
    end else if (busy && tmo_hit) begin
      // Undelivered bytes are abandoned; CS must still be raised.
      wait_d  = 1'b0;
      idx_d   = 2'd0;
      state_d = (state_q == S_CS_HI) ? S_DONE : S_CS_HI;
    end else if (busy && rsp_fire) begin
      wait_d = 1'b0;
      case (state_q)
        S_CFG0:  state_d = S_CS_LO;
        S_CS_LO: state_d = S_OPC;
        S_OPC:   state_d = quad_q ? S_TYPE : S_ADDR;
        S_TYPE:  state_d = S_ADDR;
        S_ADDR: begin
          if (idx_q == 2'd2) begin
            idx_d   = 2'd0;
            state_d = after_addr;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
        S_DUMMY: begin
          if (idx_q == DUMMY_LAST) begin
            idx_d   = 2'd0;
            state_d = after_dummy;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
        S_RD: begin
          len_d = len_q - LEN_W'(1);
          if (len_q == LEN_W'(1)) state_d = S_CS_HI;
        end
        S_CS_HI: state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    req_vld  = busy && !wait_q;
    rsp_rdy  = 1'b0;
    rd_vld   = 1'b0;
    req_addr = 4'd0;
    req_read = 1'b0;
    req_dat  = 8'h00;
    if (busy && wait_q && !tmo_hit) begin
      rsp_rdy = (state_q == S_RD) ? bus.rd_rdy : 1'b1;
      rd_vld  = (state_q == S_RD) && bus.q_rsp_vld;
    end
    case (state_q)
      S_CFG0:  begin req_addr = 4'd0; req_dat = {MODE, 1'b0, 2'b00, 3'b000}; end
      S_CS_LO: begin req_addr = 4'd1; req_dat = {DIV, 1'b0, 3'b000}; end
      S_OPC:   begin req_addr = 4'd2; req_dat = opc_q; end
      S_TYPE:  begin req_addr = 4'd0; req_dat = {MODE, 1'b0, 2'b10, 3'b000}; end
      S_ADDR: begin
        req_addr = 4'd2;
        case (idx_q)
          2'd0:    req_dat = addr_q[23:16];
          2'd1:    req_dat = addr_q[15:8];
          default: req_dat = addr_q[7:0];
        endcase
      end
      S_DUMMY: begin req_addr = 4'd2; req_dat = 8'hFF; end
      S_RD:    begin req_addr = 4'd2; req_read = 1'b1; end
      S_CS_HI: begin req_addr = 4'd1; req_dat = {DIV, 1'b1, 3'b000}; end
      default: begin req_addr = 4'd0; req_dat = 8'h00; end
    endcase
  end

`ifdef QSPI_SEQ_TIMEOUT_EN
  logic [11:0] tmo_q, tmo_d;
  logic        err_q, err_d;

  assign tmo_hit = busy && wait_q && (tmo_q == 12'hFFF);

  always_comb begin
    tmo_d = tmo_q;
    err_d = err_q;
    if (cmd_fire) begin
      tmo_d = 12'd0;
      err_d = 1'b0;
    end else if (tmo_hit) begin
      tmo_d = 12'd0;
      err_d = 1'b1;
    end else if (busy && wait_q) begin
      tmo_d = rsp_fire ? 12'd0 : tmo_q + 12'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= 12'd0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign tmo_hit = 1'b0;
  assign bus.err = 1'b0;
`endif

  assign bus.cmd_rdy    = (state_q == S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.q_req_vld  = req_vld;
  assign bus.q_req_addr = req_addr;
  assign bus.q_req_read = req_read;
  assign bus.q_req_dat  = req_dat;
  assign bus.q_rsp_rdy  = rsp_rdy;
  assign bus.rd_vld     = rd_vld;
  assign bus.rd_dat     = bus.q_rsp_dat;
  assign dbg_state_o    = state_q;

endmodule
